alu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller that drives the ALU's instruction-side interface and consumes its results. Fetches 32-bit instruction words over a req/ack memory port and reads operands from an external register file. Presents opcode, operands, immediate and flags to the ALU, then writes back the result, updates the flag pair, and redirects the PC when the ALU requests a branch. Sits between instruction memory, the register file and the ALU.

---
 rtl/alu_sequencer_pkg.sv | 36 +++
 rtl/alu_sequencer_decode.sv | 29 ++
 rtl/alu_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction field
// positions and the controller state encoding.
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD       = 6'd0;
    localparam logic [5:0] OP_SUB       = 6'd1;
    localparam logic [5:0] OP_SHL       = 6'd2;
    localparam logic [5:0] OP_SHR       = 6'd3;
    localparam logic [5:0] OP_PASS      = 6'd4;
    localparam logic [5:0] OP_LDI       = 6'd5;
    localparam logic [5:0] OP_LDI_ALT   = 6'd6;
    localparam logic [5:0] OP_PASS_ALT  = 6'd7;
    localparam logic [5:0] OP_CMP_FIRST = 6'd8;
    localparam logic [5:0] OP_CMP_LAST  = 6'd13;
    localparam logic [5:0] OP_JMP       = 6'd14;
    localparam logic [5:0] OP_BR        = 6'd15;
    localparam logic [5:0] OP_ILL_FIRST = 6'd16;
    localparam logic [5:0] OP_ILL_LAST  = 6'd62;
    localparam logic [5:0] OP_HALT      = 6'd63;

    // Instruction word layout; bit 16 carries nothing.
    localparam int OP_LSB  = 26;
    localparam int RA_LSB  = 22;
    localparam int RB_LSB  = 18;
    localparam int HL_BIT  = 17;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Opcode classifier: tells the sequencer which side effects an opcode has.
module seq_decode
    import alu_sequencer_pkg::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic [5:0] op,
    output logic       writes_reg,
    output logic       updates_flags,
    output logic       is_branch,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        writes_reg = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_SHL, OP_SHR,
            OP_PASS, OP_LDI, OP_LDI_ALT: writes_reg = 1'b1;
            OP_PASS_ALT:                 writes_reg = 1'b0;
            default:                     writes_reg = 1'b0;
        endcase
        updates_flags = (op >= OP_CMP_FIRST) && (op <= OP_CMP_LAST);
        is_branch     = (op == OP_JMP) || (op == OP_BR);
        is_halt       = (op == HALT_OP);
        is_illegal    = (op >= OP_ILL_FIRST) && (op <= OP_ILL_LAST) && !is_halt;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback controller feeding an external ALU from
// instruction memory and a register file; state exposed on state_dbg.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              REG_AW   = 4,
    parameter int              HALT_OP  = 63
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    input  logic [31:0]       rf_a_data,
    input  logic [31:0]       rf_b_data,
    input  logic [31:0]       rf_r8_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [31:0]       rf_wd,
    output logic              alu_en,
    output logic [5:0]        alu_instr,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [31:0]       alu_reg8,
    output logic [15:0]       alu_value,
    output logic              alu_highlow,
    output logic              alu_f1,
    output logic              alu_f2,
    input  logic [31:0]       alu_c,
    input  logic              alu_f3,
    input  logic              alu_addrch,
    input  logic [31:0]       alu_naddr,
    output logic              halted,
    output logic              illegal_op,
    output logic [2:0]        state_dbg
);

    localparam logic [5:0] HALT_CODE = 6'(HALT_OP);

    state_t state, state_nxt;
    // live stays low through reset so nothing is requested until it deasserts.
    logic              live;
    logic [PC_W-1:0]   pc;
    logic [5:0]        ir_op;
    logic [3:0]        ir_ra;
    logic [3:0]        ir_rb;
    logic              ir_hl;
    logic [15:0]       ir_imm;
    logic [31:0]       opa, opb, r8;
    logic              f1, f2;
    logic [31:0]       c_q;
    logic              f3_q, addrch_q;
    logic [PC_W-1:0]   naddr_q;

    logic dec_write, dec_flags, dec_branch, dec_halt, dec_illegal;

    seq_decode #(.HALT_OP(HALT_CODE)) u_decode (
        .op            (ir_op),
        .writes_reg    (dec_write),
        .updates_flags (dec_flags),
        .is_branch     (dec_branch),
        .is_halt       (dec_halt),
        .is_illegal    (dec_illegal)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= ST_FETCH;
            live     <= 1'b0;
            pc       <= RESET_PC;
            ir_op    <= '0;
            ir_ra    <= '0;
            ir_rb    <= '0;
            ir_hl    <= 1'b0;
            ir_imm   <= '0;
            opa      <= '0;
            opb      <= '0;
            r8       <= '0;
            f1       <= 1'b0;
            f2       <= 1'b0;
            c_q      <= '0;
            f3_q     <= 1'b0;
            addrch_q <= 1'b0;
            naddr_q  <= '0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            case (state)
                ST_FETCH: begin
                    if (live && imem_ack) begin
                        ir_op  <= imem_rdata[OP_LSB +: 6];
                        ir_ra  <= imem_rdata[RA_LSB +: 4];
                        ir_rb  <= imem_rdata[RB_LSB +: 4];
                        ir_hl  <= imem_rdata[HL_BIT];
                        ir_imm <= imem_rdata[IMM_LSB +: 16];
                    end
                end
                ST_DECODE: begin
                    opa <= rf_a_data;
                    opb <= rf_b_data;
                    r8  <= rf_r8_data;
                end
                ST_EXECUTE: begin
                    c_q      <= alu_c;
                    f3_q     <= alu_f3;
                    addrch_q <= alu_addrch;
                    naddr_q  <= alu_naddr[PC_W-1:0];
                end
                ST_WRITEBACK: begin
                    // Flags form a two-deep history: the older result shifts into f2.
                    if (dec_flags) begin
                        f2 <= f1;
                        f1 <= f3_q;
                    end
                    if (dec_branch && addrch_q) begin
                        pc <= naddr_q;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        rf_ra_addr  = '0;
        rf_rb_addr  = '0;
        rf_we       = 1'b0;
        rf_wa       = '0;
        rf_wd       = '0;
        alu_en      = 1'b0;
        alu_instr   = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_reg8    = '0;
        alu_value   = '0;
        alu_highlow = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = live;
                if (live && imem_ack) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                rf_ra_addr = REG_AW'(ir_ra);
                rf_rb_addr = REG_AW'(ir_rb);
                illegal_op = dec_illegal;
                state_nxt  = dec_halt ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_en      = 1'b1;
                alu_instr   = ir_op;
                alu_a       = opa;
                alu_b       = opb;
                alu_reg8    = r8;
                alu_value   = ir_imm;
                alu_highlow = ir_hl;
                state_nxt   = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (dec_write) begin
                    rf_we = 1'b1;
                    rf_wa = REG_AW'(ir_ra);
                    rf_wd = c_q;
                end
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    assign imem_addr = pc;
    assign alu_f1    = f1;
    assign alu_f2    = f2;
    assign state_dbg = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: register file and ALU are modelled by the
// bench, instruction words are handed over by a fetch driver task.
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [3:0]  rf_ra_addr, rf_rb_addr;
    logic [31:0] rf_a_data, rf_b_data, rf_r8_data;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        alu_en;
    logic [5:0]  alu_instr;
    logic [31:0] alu_a, alu_b, alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow, alu_f1, alu_f2;
    logic [31:0] alu_c;
    logic        alu_f3, alu_addrch;
    logic [31:0] alu_naddr;
    logic        halted, illegal_op;
    logic [2:0]  state_dbg;

    int vectors = 0;
    int miscompares = 0;

    alu_sequencer dut (
        .clock(clock), .resetn(resetn),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_a_data(rf_a_data), .rf_b_data(rf_b_data), .rf_r8_data(rf_r8_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .alu_en(alu_en), .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b),
        .alu_reg8(alu_reg8), .alu_value(alu_value), .alu_highlow(alu_highlow),
        .alu_f1(alu_f1), .alu_f2(alu_f2), .alu_c(alu_c), .alu_f3(alu_f3),
        .alu_addrch(alu_addrch), .alu_naddr(alu_naddr),
        .halted(halted), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Register file model with combinational reads; bench preload port for setup.
    logic [31:0] rf [16];
    logic        tb_we = 1'b0;
    logic [3:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;
    assign rf_a_data  = rf[rf_ra_addr];
    assign rf_b_data  = rf[rf_rb_addr];
    assign rf_r8_data = rf[8];
    always @(posedge clock) begin
        if (rf_we) rf[rf_wa] <= rf_wd;
        else if (tb_we) rf[tb_wa] <= tb_wd;
    end

    int alu_en_cnt = 0, we_cnt = 0, ill_cnt = 0, req_cnt = 0;
    always @(posedge clock) begin
        if (alu_en) alu_en_cnt <= alu_en_cnt + 1;
        if (rf_we) we_cnt <= we_cnt + 1;
        if (illegal_op) ill_cnt <= ill_cnt + 1;
        if (imem_req) req_cnt <= req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rf_load(input logic [3:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    // Waits (bounded) for a request, stalls 'delay' cycles, then acks with 'word'.
    // Returns at the negedge of the DECODE cycle.
    task automatic do_fetch(input logic [31:0] word, input int delay, input logic [31:0] exp_pc);
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < delay; i++) begin
            imem_rdata = 32'h00C0_0000 + i;
            @(negedge clock);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, exp_pc);
            check("wait_state", {29'd0, state_dbg}, 32'd0);
        end
        imem_rdata = word;
        imem_ack   = 1'b1;
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("decode_state", {29'd0, state_dbg}, 32'd1);
    endtask

    int en0, we0, ill0, req0;

    initial begin
        resetn = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        alu_c = '0; alu_f3 = 1'b0; alu_addrch = 1'b0; alu_naddr = '0;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        @(negedge clock);
        rf_load(4'd1, 32'd5);
        rf_load(4'd2, 32'd7);
        rf_load(4'd8, 32'h100);

        // Reset state
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_alu_en", {31'd0, alu_en}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_flags", {30'd0, alu_f2, alu_f1}, 32'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("first_req", {31'd0, imem_req}, 32'd1);

        // ADD r1 = r1 + r2
        alu_c = 32'd12;
        do_fetch(32'h0048_0000, 0, 32'd0);
        en0 = alu_en_cnt; we0 = we_cnt;
        check("add_ra", {28'd0, rf_ra_addr}, 32'd1);
        check("add_rb", {28'd0, rf_rb_addr}, 32'd2);
        check("add_dec_en", {31'd0, alu_en}, 32'd0);
        @(negedge clock);
        check("add_en", {31'd0, alu_en}, 32'd1);
        check("add_a", alu_a, 32'd5);
        check("add_b", alu_b, 32'd7);
        check("add_r8", alu_reg8, 32'h100);
        check("add_instr", {26'd0, alu_instr}, 32'd0);
        @(negedge clock);
        check("add_wb_en", {31'd0, alu_en}, 32'd0);
        check("add_we", {31'd0, rf_we}, 32'd1);
        check("add_wa", {28'd0, rf_wa}, 32'd1);
        check("add_wd", rf_wd, 32'd12);
        check("add_wb_req", {31'd0, imem_req}, 32'd0);
        @(negedge clock);
        check("add_next_req", {31'd0, imem_req}, 32'd1);
        check("add_pc", imem_addr, 32'd1);
        check("add_en_cycles", alu_en_cnt - en0, 32'd1);
        check("add_we_pulses", we_cnt - we0, 32'd1);
        check("add_rf1", rf[1], 32'd12);

        // PASS (op7) after a 3-cycle fetch stall; a stray ack in DECODE is ignored
        alu_c = 32'd55;
        we0 = we_cnt;
        do_fetch(32'h1CC0_0000, 3, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h00C0_0000;
        @(negedge clock);
        imem_ack = 1'b0;
        check("pass_instr", {26'd0, alu_instr}, 32'd7);
        @(negedge clock);
        check("pass_we", {31'd0, rf_we}, 32'd0);
        @(negedge clock);
        check("pass_pc", imem_addr, 32'd2);
        check("pass_we_pulses", we_cnt - we0, 32'd0);

        // Compare: F3=1 then F3=0 shifts the flag history
        alu_f3 = 1'b1;
        do_fetch(32'h2000_0000, 0, 32'd2);
        @(negedge clock);
        check("cmp1_instr", {26'd0, alu_instr}, 32'd8);
        @(negedge clock);
        @(negedge clock);
        check("cmp1_flags", {30'd0, alu_f2, alu_f1}, 32'b01);
        alu_f3 = 1'b0;
        we0 = we_cnt;
        do_fetch(32'h2000_0000, 0, 32'd3);
        repeat (3) @(negedge clock);
        check("cmp2_flags", {30'd0, alu_f2, alu_f1}, 32'b10);
        check("cmp2_pc", imem_addr, 32'd4);
        check("cmp_we_pulses", we_cnt - we0, 32'd0);

        // Branch taken, with immediate / highlow (bit 16 set but ignored)
        alu_addrch = 1'b1; alu_naddr = 32'h40; alu_f3 = 1'b1;
        we0 = we_cnt;
        do_fetch(32'h3C03_1234, 0, 32'd4);
        @(negedge clock);
        check("br_value", {16'd0, alu_value}, 32'h1234);
        check("br_highlow", {31'd0, alu_highlow}, 32'd1);
        check("br_instr", {26'd0, alu_instr}, 32'd15);
        repeat (2) @(negedge clock);
        check("br_taken_pc", imem_addr, 32'h40);
        check("br_flags_kept", {30'd0, alu_f2, alu_f1}, 32'b10);
        // Branch not taken
        alu_addrch = 1'b0; alu_naddr = 32'h80;
        do_fetch(32'h3C00_0000, 0, 32'h40);
        repeat (3) @(negedge clock);
        check("br_not_taken_pc", imem_addr, 32'h41);
        check("br_we_pulses", we_cnt - we0, 32'd0);

        // Jump to 9
        alu_addrch = 1'b1; alu_naddr = 32'd9;
        do_fetch(32'h3800_0000, 0, 32'h41);
        repeat (3) @(negedge clock);
        check("jmp_pc", imem_addr, 32'd9);

        // Reset in the middle of EXECUTE
        alu_addrch = 1'b0; alu_c = 32'd99;
        do_fetch(32'h0048_0000, 0, 32'd9);
        @(negedge clock);
        check("mid_en", {31'd0, alu_en}, 32'd1);
        resetn = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0048_0000;
        @(negedge clock);
        check("mr_state", {29'd0, state_dbg}, 32'd0);
        check("mr_pc", imem_addr, 32'd0);
        check("mr_en", {31'd0, alu_en}, 32'd0);
        check("mr_we", {31'd0, rf_we}, 32'd0);
        check("mr_req", {31'd0, imem_req}, 32'd0);
        check("mr_flags", {30'd0, alu_f2, alu_f1}, 32'd0);
        @(negedge clock);
        check("mr_ack_ignored", {29'd0, state_dbg}, 32'd0);
        imem_ack = 1'b0; resetn = 1'b1;
        @(negedge clock);
        check("mr_req_back", {31'd0, imem_req}, 32'd1);
        check("mr_rf1", rf[1], 32'd12);

        // Illegal opcode 20
        ill0 = ill_cnt;
        do_fetch(32'h5000_0000, 0, 32'd0);
        check("ill_pulse", {31'd0, illegal_op}, 32'd1);
        @(negedge clock);
        check("ill_pulse_end", {31'd0, illegal_op}, 32'd0);
        repeat (2) @(negedge clock);
        check("ill_pc", imem_addr, 32'd1);
        check("ill_count", ill_cnt - ill0, 32'd1);

        // Halt
        do_fetch(32'hFC00_0000, 0, 32'd1);
        check("halt_dec_halted", {31'd0, halted}, 32'd0);
        en0 = alu_en_cnt; we0 = we_cnt;
        @(negedge clock);
        req0 = req_cnt;
        check("halt_state", {29'd0, state_dbg}, 32'd4);
        check("halt_halted", {31'd0, halted}, 32'd1);
        repeat (20) @(negedge clock);
        check("halt_no_req", req_cnt - req0, 32'd0);
        check("halt_no_alu", alu_en_cnt - en0, 32'd0);
        check("halt_no_we", we_cnt - we0, 32'd0);
        check("halt_pc", imem_addr, 32'd1);
        check("halt_still", {31'd0, halted}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
